// File: rtl/dut_run_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dut_run_sequencer                                            |
// | Description : Host-side initiator for the processor start/done handshake.  |
// |               Per job: optional backdoor preload of data memory, one run   |
// |               (dut_start held until dut_done or TIMEOUT), then a readback  |
// |               window of data memory streamed out one word at a time.       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk, rst        clock, asynchronous active-low reset                     |
// |   go/load_en/rd_base/rd_count   job request, sampled only in IDLE          |
// |   load_*          preload stream (valid/ready), accepted only in LOAD      |
// |   dut_start/dut_done            processor run handshake                    |
// |   mem_*           data-memory port, owned while mem_sel=1                  |
// |   out_*           readback stream (valid/ready, last)                      |
// |   busy/job_done/timed_out/cycle_count   job status                         |
// | Options                                                                    |
// |   DONE_SYNC_EN    when defined, dut_done passes a 2-flop synchroniser      |
// +----------------------------------------------------------------------------+
module dut_run_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 16   // must not exceed 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W-1:0] rd_count,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              dut_start,
  input  logic              dut_done,
  output logic              mem_sel,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              job_done,
  output logic              timed_out,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam logic [31:0] C_TIMEOUT = 32'(TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_ARM        = 3'd2,
    ST_RUN        = 3'd3,
    ST_DRAIN_ADDR = 3'd4,
    ST_DRAIN_CAP  = 3'd5,
    ST_DRAIN_OUT  = 3'd6,
    ST_FINISH     = 3'd7
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [ADDR_W-1:0]   r_rd_addr;     // current readback address
  logic [ADDR_W-1:0]   r_rd_left;     // readback words not yet accepted
  logic [CNT_W-1:0]    r_cycle_count;
  logic                r_timed_out;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_last;

  logic                w_done;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                w_run_first;
  logic                w_timeout_hit;

  // ---------------------------------------------------------------------------
  // dut_done qualification
  // ---------------------------------------------------------------------------
`ifdef DONE_SYNC_EN
  logic [1:0] r_done_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done_sync <= 2'b00;
    end else begin
      r_done_sync <= {r_done_sync[0], dut_done};
    end
  end

  assign w_done = r_done_sync[1];
`else
  assign w_done = dut_done;
`endif

  // Saturating run counter; cycle_count is cleared on go, so a zero count
  // while in RUN identifies the first run cycle (where done is ignored).
  assign w_cnt_inc   = (r_cycle_count == {CNT_W{1'b1}}) ? r_cycle_count
                                                        : r_cycle_count + 1'b1;
  assign w_run_first = (r_cycle_count == '0);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and state-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next  = r_state;
    w_timeout_hit = 1'b0;
    dut_start     = 1'b0;
    mem_sel       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    load_ready    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (go) begin
          w_state_next = load_en ? ST_LOAD : ST_ARM;
        end
      end

      ST_LOAD: begin
        // Preload beats pass straight through to the memory port.
        mem_sel    = 1'b1;
        load_ready = 1'b1;
        if (load_valid) begin
          mem_we    = 1'b1;
          mem_addr  = load_addr;
          mem_wdata = load_data;
          if (load_last) begin
            w_state_next = ST_ARM;
          end
        end
      end

      // Single cycle with dut_start low so the processor always sees reset.
      ST_ARM: begin
        w_state_next = ST_RUN;
      end

      ST_RUN: begin
        dut_start = 1'b1;
        if (!w_run_first && w_done) begin
          w_state_next = (r_rd_left != '0) ? ST_DRAIN_ADDR : ST_FINISH;
        end else if (32'(w_cnt_inc) >= C_TIMEOUT) begin
          w_timeout_hit = 1'b1;
          w_state_next  = ST_FINISH;
        end
      end

      ST_DRAIN_ADDR: begin
        mem_sel      = 1'b1;
        mem_addr     = r_rd_addr;
        w_state_next = ST_DRAIN_CAP;
      end

      // Address held so the registered read data stays aligned with it.
      ST_DRAIN_CAP: begin
        mem_sel      = 1'b1;
        mem_addr     = r_rd_addr;
        w_state_next = ST_DRAIN_OUT;
      end

      ST_DRAIN_OUT: begin
        mem_sel = 1'b1;
        if (out_ready) begin
          w_state_next = (r_rd_left == ADDR_W'(1)) ? ST_FINISH : ST_DRAIN_ADDR;
        end
      end

      ST_FINISH: begin
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Job datapath: latched request, run counter, readback word
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_addr     <= '0;
      r_rd_left     <= '0;
      r_cycle_count <= '0;
      r_timed_out   <= 1'b0;
      r_out_data    <= '0;
      r_out_last    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (go) begin
            r_rd_addr     <= rd_base;
            r_rd_left     <= rd_count;
            r_cycle_count <= '0;
            r_timed_out   <= 1'b0;
          end
        end

        ST_RUN: begin
          r_cycle_count <= w_cnt_inc;
          if (w_timeout_hit) begin
            r_timed_out <= 1'b1;
          end
        end

        ST_DRAIN_CAP: begin
          r_out_data <= mem_rdata;
          r_out_last <= (r_rd_left == ADDR_W'(1));
        end

        ST_DRAIN_OUT: begin
          if (out_ready) begin
            r_out_last <= 1'b0;
            r_rd_addr  <= r_rd_addr + 1'b1;   // wraps modulo 2^ADDR_W
            r_rd_left  <= r_rd_left - 1'b1;
          end
        end

        default: begin
        end
      endcase
    end
  end

  assign out_valid   = (r_state == ST_DRAIN_OUT);
  assign out_data    = r_out_data;
  assign out_last    = r_out_last;
  assign busy        = (r_state != ST_IDLE);
  assign job_done    = (r_state == ST_FINISH);
  assign timed_out   = r_timed_out;
  assign cycle_count = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_dut_run_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dut_run_sequencer                                         |
// | Description : Self-checking bench for dut_run_sequencer. Provides a data   |
// |               memory, a processor model that raises done after a chosen    |
// |               number of run cycles, and a job-level reference model.       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_dut_run_sequencer;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 50;
  localparam int CNT_W   = 16;
`ifdef DONE_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              go;
  logic              load_en;
  logic [ADDR_W-1:0] rd_base;
  logic [ADDR_W-1:0] rd_count;
  logic              load_valid;
  logic              load_ready;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              dut_start;
  logic              dut_done;
  logic              mem_sel;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              job_done;
  logic              timed_out;
  logic [CNT_W-1:0]  cycle_count;

  int n_checks = 0;
  int n_errors = 0;

  // memory, processor model and preload job description
  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  logic       init_we;
  logic [7:0] init_addr;
  logic [7:0] init_data;
  int         done_at;
  int         run_cyc = 0;
  logic [7:0] q_baddr[$];
  logic [7:0] q_bdata[$];

  always #5 clk = ~clk;

  dut_run_sequencer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .load_en    (load_en),
    .rd_base    (rd_base),
    .rd_count   (rd_count),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .load_last  (load_last),
    .dut_start  (dut_start),
    .dut_done   (dut_done),
    .mem_sel    (mem_sel),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .job_done   (job_done),
    .timed_out  (timed_out),
    .cycle_count(cycle_count)
  );

  // synchronous-read data memory
  always @(posedge clk) begin
    if (init_we) mem[init_addr] <= init_data;
    else if (mem_sel && mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // processor: done held high from its done_at-th start-high cycle onwards
  always @(posedge clk) run_cyc <= dut_start ? run_cyc + 1 : 0;
  assign dut_done = dut_start && (done_at != 0) && (run_cyc + 1 >= done_at);

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // cycle at which done is recognised (done is ignored in the first run cycle)
  function automatic int done_seen_at(input int dn);
    int e;
    e = dn + SYNC_LAT;
    return (e < 2) ? 2 : e;
  endfunction

  function automatic bit exp_timeout(input int dn);
    return (dn == 0) || (done_seen_at(dn) > TIMEOUT);
  endfunction

  function automatic int exp_run(input int dn);
    return exp_timeout(dn) ? TIMEOUT : done_seen_at(dn);
  endfunction

  task automatic run_job(input bit ld, input int dn, input logic [7:0] base,
                         input logic [7:0] cnt, input int stall);
    int  exp_cyc, exp_words;
    bit  exp_to;
    int  start_cyc = 0, words = 0, n_ov = 0, n_stray = 0, n_sel_after = 0;
    int  n_sel_run = 0, n_unstable = 0, stall_left = 0, n_jd = 0;
    bit  got_done = 0, was_started = 0, fell = 0, new_word = 1;
    logic [7:0] held = '0;

    exp_cyc   = exp_run(dn);
    exp_to    = exp_timeout(dn);
    exp_words = exp_to ? 0 : int'(cnt);

    @(negedge clk);
    go = 1'b1; load_en = ld; rd_base = base; rd_count = cnt; done_at = dn;
    @(negedge clk);
    go = 1'b0; load_en = 1'($urandom); rd_base = 8'($urandom); rd_count = 8'($urandom);
    check_val("busy_after_go", 32'(busy), 32'd1);

    if (ld) begin
      foreach (q_baddr[b]) begin
        int gap = $urandom_range(0, 2);
        repeat (gap) begin
          load_valid = 1'b0; load_addr = 8'($urandom); load_data = 8'($urandom);
          load_last = 1'($urandom);
          #1;
          if (mem_we) n_stray++;
          @(negedge clk);
        end
        load_valid = 1'b1; load_addr = q_baddr[b]; load_data = q_bdata[b];
        load_last  = (b == q_baddr.size() - 1);
        #1;
        check_val("preload_beat", 32'({mem_sel, load_ready, mem_we, mem_addr, mem_wdata}),
                  32'({3'b111, q_baddr[b], q_bdata[b]}));
        ref_mem[q_baddr[b]] = q_bdata[b];
        @(negedge clk);
      end
    end
    load_valid = 1'b0; load_last = 1'b0;

    for (int cyc = 0; cyc < 400; cyc++) begin
      load_valid = 1'($urandom); load_addr = 8'($urandom); load_data = 8'($urandom);
      load_last = 1'($urandom); go = 1'($urandom); load_en = 1'($urandom);
      rd_base = 8'($urandom); rd_count = 8'($urandom);
      #1;
      if (mem_we) n_stray++;
      if (dut_start) begin
        start_cyc++; was_started = 1;
        if (mem_sel) n_sel_run++;
      end else if (was_started) begin
        fell = 1;
      end
      if (fell && mem_sel) n_sel_after++;
      if (out_valid) begin
        n_ov++;
        if (new_word) begin
          check_val("out_data", 32'(out_data), 32'(ref_mem[8'(int'(base) + words)]));
          check_val("out_last", 32'(out_last), 32'(words == int'(cnt) - 1));
          held = out_data; new_word = 0; stall_left = stall;
        end else if (out_data !== held) begin
          n_unstable++;
        end
        if (stall_left > 0) begin
          out_ready = 1'b0; stall_left--;
        end else begin
          out_ready = 1'b1; words++; new_word = 1;
        end
      end else begin
        out_ready = 1'($urandom);
      end
      if (job_done) begin
        got_done = 1; n_jd = 1;
        go = 1'b0; load_valid = 1'b0; out_ready = 1'b0;
        break;
      end
      @(negedge clk);
    end

    check_val("job_done_seen", 32'(got_done), 32'd1);
    check_val("busy_in_finish", 32'(busy), 32'd1);
    check_val("cycle_count", 32'(cycle_count), 32'(exp_cyc));
    check_val("timed_out", 32'(timed_out), 32'(exp_to));
    check_val("start_cycles", 32'(start_cyc), 32'(exp_cyc));
    check_val("words", 32'(words), 32'(exp_words));
    check_val("out_valid_any", 32'(n_ov != 0), 32'(exp_words != 0));
    check_val("stray_we", 32'(n_stray), 32'd0);
    check_val("out_unstable", 32'(n_unstable), 32'd0);
    check_val("sel_during_run", 32'(n_sel_run), 32'd0);
    check_val("sel_after_run", 32'(n_sel_after != 0), 32'(exp_words != 0));

    @(negedge clk);
    check_val("busy_idle", 32'(busy), 32'd0);
    repeat (3) begin
      if (job_done) n_jd++;
      @(negedge clk);
    end
    check_val("job_done_once", 32'(n_jd), 32'd1);
  endtask

  initial begin
    rst = 1'b0; go = 1'b0; load_en = 1'b0; rd_base = '0; rd_count = '0;
    load_valid = 1'b1; load_addr = 8'h33; load_data = 8'h44; load_last = 1'b1;
    out_ready = 1'b0; done_at = 0; init_we = 1'b0; init_addr = '0; init_data = '0;

    // fill memory with known random content while held in reset
    for (int i = 0; i < 256; i++) begin
      init_we = 1'b1; init_addr = 8'(i); init_data = 8'($urandom);
      ref_mem[i] = init_data;
      @(negedge clk);
    end
    init_we = 1'b0;
    check_val("reset_flags", 32'({dut_start, mem_sel, mem_we, load_ready, out_valid,
                                  out_last, busy, job_done, timed_out}), 32'd0);
    check_val("reset_cycle_count", 32'(cycle_count), 32'd0);
    load_valid = 1'b0; load_last = 1'b0;
    rst = 1'b1;

    // load-run-read
    q_baddr = '{8'h10, 8'h11, 8'h12}; q_bdata = '{8'hAA, 8'hBB, 8'hCC};
    run_job(1'b1, 20, 8'h10, 8'd3, 0);
    // timeout, readback skipped
    run_job(1'b0, 0, 8'h20, 8'd4, 0);
    // wrap with backpressure
    q_baddr = '{8'hFE, 8'hFF, 8'h00}; q_bdata = '{8'h11, 8'h22, 8'h33};
    run_job(1'b1, 10, 8'hFE, 8'd3, 5);
    // no readback, no preload
    run_job(1'b0, 7, 8'h05, 8'd0, 0);
    // done boundaries: first-cycle done, done exactly at TIMEOUT, just late
    run_job(1'b0, 1, 8'h80, 8'd1, 1);
    run_job(1'b0, TIMEOUT - SYNC_LAT, 8'h81, 8'd2, 0);
    run_job(1'b0, TIMEOUT - SYNC_LAT + 1, 8'h82, 8'd2, 0);

    // go ignored in RUN, then asynchronous reset mid-run
    @(negedge clk);
    go = 1'b1; load_en = 1'b0; rd_base = 8'h40; rd_count = 8'd2; done_at = 0;
    @(negedge clk);
    go = 1'b0;
    for (int k = 0; k < 20 && !dut_start; k++) @(negedge clk);
    check_val("run_reached", 32'(dut_start), 32'd1);
    repeat (5) begin
      go = 1'b1; load_en = 1'b1;
      @(negedge clk);
    end
    go = 1'b0; load_en = 1'b0;
    check_val("go_ignored_in_run", 32'({dut_start, busy, load_ready}), 32'b110);
    #2 rst = 1'b0;
    #1;
    check_val("async_reset_mid_run", 32'({dut_start, busy, job_done, mem_sel, out_valid}), 32'd0);
    check_val("reset_clears_count", 32'(cycle_count), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    begin
      int n_bad = 0;
      repeat (5) begin
        @(negedge clk);
        if (job_done || busy) n_bad++;
      end
      check_val("no_done_after_reset", 32'(n_bad), 32'd0);
    end
    q_baddr = '{8'h50}; q_bdata = '{8'h5A};
    run_job(1'b1, 12, 8'h50, 8'd2, 2);

    // randomized jobs
    for (int j = 0; j < 20; j++) begin
      bit         ld;
      int         dn, nb, stall;
      logic [7:0] base, cnt;
      ld    = 1'($urandom);
      base  = 8'($urandom);
      cnt   = 8'($urandom_range(0, 5));
      stall = $urandom_range(0, 3);
      dn    = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 60);
      nb    = $urandom_range(1, 4);
      q_baddr.delete(); q_bdata.delete();
      for (int b = 0; b < nb; b++) begin
        q_baddr.push_back(8'(int'(base) + $urandom_range(0, 5)));
        q_bdata.push_back(8'($urandom));
      end
      run_job(ld, dn, base, cnt, stall);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
